// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM encoding and op-class helpers.
package mdu_pkg;

   localparam int MDU_OPW = 4;

   typedef enum logic [MDU_OPW-1:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

   function automatic logic op_is_div(input mdu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_mul(input mdu_op_e op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
             (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
   import mdu_pkg::*;

   logic                 start;
   logic [MDU_OPW-1:0]   op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 cancel;
   logic                 busy;
   logic                 done;
   logic                 div_zero;
   logic [WIDTH-1:0]     hi;
   logic [WIDTH-1:0]     lo;

   modport master (output start, op, a, b, cancel,
                   input  busy, done, div_zero, hi, lo);
   modport slave  (input  start, op, a, b, cancel,
                   output busy, done, div_zero, hi, lo);

endinterface

// File: rtl/mdu_core_calc.sv
// Combinational datapath: full {hi,lo} result and divide-by-zero flag
// for one op, given the operands and the current HI/LO pair.
module mdu_core_calc
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  mdu_op_e            i_op,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic [2*WIDTH-1:0] i_hilo,
   output logic [2*WIDTH-1:0] o_result,
   output logic               o_div_zero
);

   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] w_sa, w_sb;
   logic [2*WIDTH-1:0]        w_sprod, w_uprod;
   logic                      w_b_zero, w_ovf;
   logic [WIDTH-1:0]          w_sdivisor, w_udivisor;
   logic [WIDTH-1:0]          w_squo, w_srem, w_uquo, w_urem;

   assign w_sa    = {{WIDTH{i_a[WIDTH-1]}}, i_a};
   assign w_sb    = {{WIDTH{i_b[WIDTH-1]}}, i_b};
   assign w_sprod = w_sa * w_sb;
   assign w_uprod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

   // Dividing by 1 yields exactly the required MOST_NEG/-1 result
   // (quotient MOST_NEG, remainder 0) and keeps the divider in range.
   assign w_b_zero   = (i_b == '0);
   assign w_ovf      = (i_a == MOST_NEG) && (&i_b);
   assign w_sdivisor = (w_b_zero || w_ovf) ? ONE : i_b;
   assign w_udivisor = w_b_zero ? ONE : i_b;
   assign w_squo     = $signed(i_a) / $signed(w_sdivisor);
   assign w_srem     = $signed(i_a) % $signed(w_sdivisor);
   assign w_uquo     = i_a / w_udivisor;
   assign w_urem     = i_a % w_udivisor;

   always_comb begin
      o_result   = i_hilo;
      o_div_zero = 1'b0;
      case (i_op)
         OP_MULT:  o_result = w_sprod;
         OP_MULTU: o_result = w_uprod;
         OP_MADD:  o_result = i_hilo + w_sprod;
         OP_MADDU: o_result = i_hilo + w_uprod;
         OP_MSUB:  o_result = i_hilo - w_sprod;
         OP_MSUBU: o_result = i_hilo - w_uprod;
         OP_DIV, OP_DIVU: begin
            if (w_b_zero) begin
               o_result   = {i_a, {WIDTH{1'b1}}};
               o_div_zero = 1'b1;
            end else if (i_op == OP_DIV) begin
               o_result = {w_srem, w_squo};
            end else begin
               o_result = {w_urem, w_uquo};
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_iter.sv
// Multiply/divide unit with fixed-latency busy window, HI/LO ownership
// and flush cancellation. Result is computed at accept and held until commit.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic  clk,
   input  logic  reset,
   mdu_if.slave  bus
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   mdu_state_e         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [2*WIDTH-1:0] r_result, w_calc;
   logic               r_calc_dz, w_calc_dz;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_done, r_div_zero;
   mdu_op_e            w_op;
   logic               w_single, w_multi, w_accept, w_commit;

   assign w_op     = mdu_op_e'(bus.op);
   assign w_single = (w_op == OP_MTHI) || (w_op == OP_MTLO);
   assign w_multi  = op_is_mul(w_op) || op_is_div(w_op);

   mdu_core_calc #(.WIDTH(WIDTH)) u_calc (
      .i_op       (w_op),
      .i_a        (bus.a),
      .i_b        (bus.b),
      .i_hilo     ({r_hi, r_lo}),
      .o_result   (w_calc),
      .o_div_zero (w_calc_dz)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Accept only from IDLE, so start while busy is dropped; cancel beats commit.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start && !bus.cancel && (w_single || w_multi)) begin
               w_accept = 1'b1;
               if (w_multi) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = op_is_div(w_op) ? CNT_W'(DIV_CYCLES - 1)
                                                : CNT_W'(MUL_CYCLES - 1);
               end
            end
         end
         RUN: begin
            if (bus.cancel) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               w_commit    = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_result   <= '0;
         r_calc_dz  <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_done <= w_commit;
         if (w_accept) begin
            r_div_zero <= 1'b0;
            r_result   <= w_calc;
            r_calc_dz  <= w_calc_dz;
            if (w_op == OP_MTHI) r_hi <= bus.a;
            if (w_op == OP_MTLO) r_lo <= bus.a;
         end
         if (w_commit) begin
            {r_hi, r_lo} <= r_result;
            r_div_zero   <= r_calc_dz;
         end
      end
   end

   assign bus.busy     = (r_state == RUN);
   assign bus.done     = r_done;
   assign bus.div_zero = r_div_zero;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit for the EX stage. Owns the HI/LO registers.
- Executes signed and unsigned MULT, DIV, MADD and MSUB with configurable latency, plus MTHI and MTLO.
- Exposes busy so hazard logic can stall MFHI/MFLO and further MDU ops. Stall condition is start|busy.
- Supports cancellation when the issuing instruction is flushed by an exception or interrupt.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, busy cycles for MULT/MULTU/MADD*/MSUB* (≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  op valid this cycle.
- op  in  4  operation code, see Decomposition.
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- cancel  in  1  flush: abort in-flight op and suppress an op starting this cycle.
- busy  out  1  multi-cycle op in flight.
- done  out  1  one-cycle pulse: HI/LO just committed by a multi-cycle op.
- div_zero  out  1  last committed DIV/DIVU had b==0; cleared by next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, FSM=IDLE. This aborts any in-flight op.
- FSM states: IDLE and RUN.
- Accept rule: an op is accepted at a rising edge where start=1, busy=0, cancel=0, op≠NOP.
  - start while busy is ignored; no queueing.
  - Unknown op codes are treated as NOP.
- MTHI/MTLO: single cycle. hi (or lo) ← a at the accepting edge. busy stays 0, no done.
- Multi-cycle op accepted:
  - Operands and op are latched and the result is computed into an internal 2·WIDTH result register.
  - FSM→RUN, busy=1, counter=N-1, where N = MUL_CYCLES or DIV_CYCLES.
  - busy is high for exactly N cycles following the accept edge.
  - At the edge where counter==0 in RUN: hi/lo ← result, busy→0, done=1 for the next cycle, FSM→IDLE.
  - A new start in the cycle done is high is accepted.
- cancel=1 while in RUN: at the next edge FSM→IDLE, busy→0, hi/lo and div_zero unchanged, no done.
- cancel has priority over completion in the same cycle.
- Arithmetic:
  - MULT/MULTU: {hi,lo} = signed/unsigned a·b, full 2·WIDTH product.
  - MADD/MADDU: {hi,lo} = {hi,lo} + a·b, using the {hi,lo} value at accept time. MSUB/MSUBU subtract instead. Wrap modulo 2^(2·WIDTH).
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of a.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: lo = all-ones, hi = a, div_zero=1 on commit. No exception is raised.
  - DIV of most-negative by -1: lo = most-negative, hi = 0, no flag.
- hi/lo are only ever written at accept (MTHI/MTLO) or at commit. They are stable otherwise, including during RUN.

Decomposition:
- Shared package mdu_pkg:
  - op codes: NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10.
  - state encoding: IDLE=0, RUN=1.
  - helper constant: MDU_OPW=4.
- One sub-module, mdu_core_calc: purely combinational 2·WIDTH result plus div_zero flag from op, a, b, {hi,lo}.
- The top holds the FSM, counter, latches, HI/LO, and cancel handling.

Test Plan (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10):
- MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7, div_zero=1; next accepted MULT clears div_zero.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. MTLO 0xFFFFFFFF, MTHI 0 (each single cycle, busy stays 0) then MADD a=1, b=1 -> hi=1, lo=0.
- Start DIV, cancel=1 in 3rd busy cycle -> busy=0 next cycle, hi/lo unchanged, no done. Start+cancel same cycle -> not accepted. start during busy -> ignored, final hi/lo from first op only.
- reset pulsed low mid-MULT (async, between edges) -> busy, done, hi, lo drop to 0 immediately; no commit after release.
